// File: rtl/counter_seq_pkg.sv
// Shared constants for the counter sequencing controller: state encoding,
// command opcodes and run-mode codes.
// Optional build macro used by this slice: COUNTER_SEQ_EXTTRIG_EN.
package counter_seq_pkg;

    // Controller states, also the encoding seen on state_o.
    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_CLEARING = 2'b01;
    localparam logic [1:0] ST_RUNNING  = 2'b10;
    localparam logic [1:0] ST_PAUSED   = 2'b11;

    // Command opcodes carried on cmd_op.
    localparam logic [1:0] OP_STOP       = 2'b00;
    localparam logic [1:0] OP_START      = 2'b01;
    localparam logic [1:0] OP_LOAD_LIMIT = 2'b10;
    localparam logic [1:0] OP_CLEAR      = 2'b11;

    // Run modes; code 2'b11 is reserved and runs as one-shot.
    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_FREERUN  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    // Fold the reserved mode code onto one-shot.
    function automatic logic [1:0] decode_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_ONESHOT : m;
    endfunction

endpackage

// File: rtl/counter_seq_tick.sv
// Tick generator for the counter sequencer. Default build: a prescaler that
// fires every prescale+1 cycles while run is high and restarts from zero when
// restart is asserted. With COUNTER_SEQ_EXTTRIG_EN defined, the tick instead
// comes from a synchronised rising edge of ext_tick (3 cycle latency).
module counter_seq_tick #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
`ifdef COUNTER_SEQ_EXTTRIG_EN
    input  logic                  ext_tick,
`endif
    output logic                  tick
);

`ifdef COUNTER_SEQ_EXTTRIG_EN

    logic sync1_q, sync2_q, prev_q, edge_q;
    logic unused_ext;

    // The prescaler is bypassed entirely in this build.
    assign unused_ext = ^{prescale, restart};

    // Two-flop synchroniser, previous-value flop and registered edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= ext_tick;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    // Edges arriving outside RUNNING are dropped.
    assign tick = run & edge_q;

`else

    logic [PRESCALE_W-1:0] pre_q, pre_d;

    // Tick when the count has reached the period; >= keeps a shrinking
    // prescale from forcing a long wrap-around.
    assign tick = run && (pre_q >= prescale);

    // Prescaler next-state: held at zero outside RUNNING and on entry.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
        pre_d = pre_q;
        if (restart || !run) begin
            pre_d = '0;
        end else if (pre_q >= prescale) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

`endif

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a BITS-wide up/down counter datapath. Accepts
// STOP/START/LOAD_LIMIT/CLEAR over valid/ready and drives the counter's
// enable, direction and clear strobes at the tick rate, in one-shot,
// free-run or ping-pong mode.
// Optional build macro: COUNTER_SEQ_EXTTRIG_EN (adds ext_tick, which replaces
// the prescaler as tick source).
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int BITS       = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [BITS-1:0]       cmd_data,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BITS-1:0]       count_i,
`ifdef COUNTER_SEQ_EXTTRIG_EN
    input  logic                  ext_tick,
`endif
    output logic                  cnt_en,
    output logic                  cnt_up,
    output logic                  cnt_clr,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_o
);

    logic [1:0]      state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [BITS-1:0] limit_q, limit_d;
    logic            dir_q, dir_d;
    logic            accept;
    logic            tick;
    logic            run;
    logic            restart;
    logic            eff_up;

    assign cmd_ready = (state_q != ST_CLEARING);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q == ST_CLEARING) || (state_q == ST_RUNNING);
    assign state_o   = state_q;
    assign run       = (state_q == ST_RUNNING);
    // The prescaler phase restarts on every entry into RUNNING.
    assign restart   = (state_d == ST_RUNNING) && (state_q != ST_RUNNING);

    counter_seq_tick #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .run      (run),
        .prescale (prescale),
`ifdef COUNTER_SEQ_EXTTRIG_EN
        .ext_tick (ext_tick),
`endif
        .tick     (tick)
    );

    // FSM, mode/direction decisions and counter strobes.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        limit_d = limit_q;
        dir_d   = dir_q;
        cnt_en  = 1'b0;
        cnt_up  = dir_q;
        cnt_clr = 1'b0;
        done    = 1'b0;
        eff_up  = dir_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && cmd_op == OP_START) begin
                    mode_d  = decode_mode(mode);
                    dir_d   = 1'b1;
                    state_d = ST_CLEARING;
                end
            end
            ST_CLEARING: begin
                cnt_clr = 1'b1;
                state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (tick) begin
                    case (mode_q)
                        MODE_FREERUN: begin
                            cnt_en = 1'b1;
                            cnt_up = 1'b1;
                            done   = (count_i == limit_q);
                        end
                        MODE_PINGPONG: begin
                            if (limit_q == '0) begin
                                // Degenerate range: nothing to sweep.
                                done = 1'b1;
                            end else begin
                                // Reverse at the top (limit) or bottom (zero).
                                eff_up = dir_q ? (count_i != limit_q) : (count_i == '0);
                                cnt_en = 1'b1;
                                cnt_up = eff_up;
                                dir_d  = eff_up;
                                done   = dir_q && !eff_up;
                            end
                        end
                        default: begin
                            if (count_i != limit_q) begin
                                cnt_en = 1'b1;
                                cnt_up = 1'b1;
                            end else begin
                                done    = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                    endcase
                end
                // A one-shot finishing on this tick takes precedence over STOP.
                if (accept && cmd_op == OP_STOP && state_d == ST_RUNNING) begin
                    state_d = ST_PAUSED;
                end
            end
            default: begin
                if (accept && cmd_op == OP_START) begin
                    state_d = ST_RUNNING;
                end
            end
        endcase

        if (accept && cmd_op == OP_LOAD_LIMIT) begin
            limit_d = cmd_data;
        end

        // CLEAR overrides whatever the state logic decided this cycle.
        if (accept && cmd_op == OP_CLEAR) begin
            cnt_clr = 1'b1;
            cnt_en  = 1'b0;
            done    = 1'b0;
            dir_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_ONESHOT;
            limit_q <= '1;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl. Models the registered up/down counter
// the controller drives and checks strobes, state and count against
// hand-computed sequences.
module tb_counter_seq_ctrl;

    localparam int BITS       = 4;
    localparam int PRESCALE_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic [1:0]            cmd_op = 2'b00;
    logic [BITS-1:0]       cmd_data = '0;
    logic [1:0]            mode = 2'b00;
    logic [PRESCALE_W-1:0] prescale = '0;
    logic [BITS-1:0]       count_i;
    logic                  cnt_en, cnt_up, cnt_clr, busy, done;
    logic [1:0]            state_o;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    // Ping-pong expectations (limit 3, prescale 1), one entry per RUNNING cycle.
    int pp_cnt  [16] = '{0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0, 1, 1};
    int pp_up   [16] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int pp_done [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    counter_seq_ctrl #(
        .BITS       (BITS),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .mode      (mode),
        .prescale  (prescale),
        .count_i   (count_i),
`ifdef COUNTER_SEQ_EXTTRIG_EN
        .ext_tick  (1'b0),
`endif
        .cnt_en    (cnt_en),
        .cnt_up    (cnt_up),
        .cnt_clr   (cnt_clr),
        .busy      (busy),
        .done      (done),
        .state_o   (state_o)
    );

    // Registered counter datapath: clear wins over enable.
    logic [BITS-1:0] cnt_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt_m <= '0;
        else if (cnt_clr) cnt_m <= '0;
        else if (cnt_en)  cnt_m <= cnt_up ? cnt_m + 1'b1 : cnt_m - 1'b1;
    end
    assign count_i = cnt_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and let combinational outputs settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present one command for exactly one rising edge.
    task automatic send_cmd(input logic [1:0] op, input logic [BITS-1:0] data);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        // ---------------- reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", state_o, 0);
        check("rst_en", cnt_en, 0);
        check("rst_up", cnt_up, 1);
        check("rst_clr", cnt_clr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // ---------------- one-shot, limit 5, prescale 0
        send_cmd(2'b10, 4'd5);
        mode = 2'b00;
        prescale = 8'd0;
        send_cmd(2'b01, 4'd0);
        check("os_clr_state", state_o, 1);
        check("os_clr_strobe", cnt_clr, 1);
        check("os_clr_ready", cmd_ready, 0);
        check("os_clr_busy", busy, 1);
        for (int r = 0; r <= 5; r++) begin
            step();
            check("os_state", state_o, 2);
            check("os_count", count_i, r);
            check("os_en", cnt_en, (r < 5) ? 1 : 0);
            check("os_done", done, (r == 5) ? 1 : 0);
            check("os_noclr", cnt_clr, 0);
        end
        step();
        check("os_idle", state_o, 0);
        check("os_hold", count_i, 5);
        check("os_done_once", done, 0);

        // ---------------- ping-pong, limit 3, prescale 1
        send_cmd(2'b10, 4'd3);
        mode = 2'b10;
        prescale = 8'd1;
        send_cmd(2'b01, 4'd0);
        check("pp_clr", cnt_clr, 1);
        for (int r = 0; r < 16; r++) begin
            step();
            check("pp_count", count_i, pp_cnt[r]);
            check("pp_en", cnt_en, r % 2);
            check("pp_up", cnt_up, pp_up[r]);
            check("pp_done", done, pp_done[r]);
        end
        send_cmd(2'b11, 4'd0);
        check("pp_cleared", state_o, 0);

        // ---------------- free-run, limit 15, prescale 2
        send_cmd(2'b10, 4'd15);
        mode = 2'b01;
        prescale = 8'd2;
        send_cmd(2'b01, 4'd0);
        for (int k = 0; k < 18; k++) begin
            step();
            step();
            check("fr_gap_en", cnt_en, 0);
            step();
            check("fr_tick_en", cnt_en, 1);
            check("fr_count", count_i, k % 16);
            check("fr_done", done, (k % 16 == 15) ? 1 : 0);
        end
        check("fr_running", state_o, 2);
        send_cmd(2'b11, 4'd0);
        check("fr_cleared", state_o, 0);

        // ---------------- STOP / resume in one-shot, limit 6
        send_cmd(2'b10, 4'd6);
        mode = 2'b00;
        prescale = 8'd0;
        send_cmd(2'b01, 4'd0);
        step();
        check("sp_r0", count_i, 0);
        send_cmd(2'b00, 4'd0);
        check("sp_paused", state_o, 3);
        check("sp_count", count_i, 2);
        check("sp_busy", busy, 0);
        repeat (10) step();
        check("sp_hold", count_i, 2);
        check("sp_hold_en", cnt_en, 0);
        send_cmd(2'b01, 4'd0);
        check("sp_resumed", state_o, 2);
        check("sp_noclr", cnt_clr, 0);
        for (int c = 2; c <= 6; c++) begin
            if (c > 2) step();
            check("sp_count_run", count_i, c);
            check("sp_done", done, (c == 6) ? 1 : 0);
        end
        step();
        check("sp_idle", state_o, 0);

        // ---------------- CLEAR while RUNNING at count 9; CLEAR during CLEARING refused
        send_cmd(2'b10, 4'd15);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        @(negedge clk);
        cmd_op    = 2'b11;
        #1;
        check("cl_ready_low", cmd_ready, 0);
        check("cl_in_clearing", state_o, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        check("cl_ignored", state_o, 2);
        check("cl_r0", count_i, 0);
        repeat (8) step();
        check("cl_r8", count_i, 8);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        #1;
        check("cl_at9", count_i, 9);
        check("cl_strobe", cnt_clr, 1);
        check("cl_no_en", cnt_en, 0);
        check("cl_no_done", done, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        check("cl_idle", state_o, 0);
        check("cl_zeroed", count_i, 0);
        check("cl_strobe_1cyc", cnt_clr, 0);
        check("cl_done_after", done, 0);

        // ---------------- reset mid-RUNNING restores limit 15 and mode
        send_cmd(2'b10, 4'd7);
        mode = 2'b01;
        prescale = 8'd0;
        send_cmd(2'b01, 4'd0);
        repeat (3) step();
        check("mr_running", state_o, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_state", state_o, 0);
        check("mr_en", cnt_en, 0);
        check("mr_up", cnt_up, 1);
        check("mr_clr", cnt_clr, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        mode = 2'b11;
        send_cmd(2'b01, 4'd0);
        for (int r = 0; r <= 15; r++) begin
            step();
            check("mr_count", count_i, r);
            check("mr_lim_done", done, (r == 15) ? 1 : 0);
            check("mr_lim_en", cnt_en, (r < 15) ? 1 : 0);
        end
        step();
        check("mr_oneshot_end", state_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
